shift_reg_univ: RTL and testbench



---
 rtl/shift_reg_pkg.sv | 15 +
 rtl/shift_reg_univ.sv | 79 +++++++
 tb/tb_shift_reg_univ.sv | 139 +++++++++++++
 3 files changed

// File: rtl/shift_reg_pkg.sv
// rtl/shift_reg_pkg.sv - mode encodings and FSM state type for shift_reg_univ
package shift_reg_pkg;

    localparam logic [1:0] MODE_HOLD = 2'b00;
    localparam logic [1:0] MODE_SHR  = 2'b01;
    localparam logic [1:0] MODE_SHL  = 2'b10;
    localparam logic [1:0] MODE_LOAD = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_t;

endpackage

// File: rtl/shift_reg_univ.sv
// rtl/shift_reg_univ.sv - universal shift register with autonomous burst serialiser
module shift_reg_univ
    import shift_reg_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit BURST_DIR = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       mode,
    input  logic             s_in_msb,
    input  logic             s_in_lsb,
    input  logic [WIDTH-1:0] p_in,
    input  logic             start,
    output logic [WIDTH-1:0] p_out,
    output logic             s_out_lsb,
    output logic             s_out_msb,
    output logic             busy,
    output logic             done
);

    localparam int CW = $clog2(WIDTH + 1);

    state_t           state, state_nxt;
    logic [CW-1:0]    cnt, cnt_nxt;
    logic [WIDTH-1:0] q, q_nxt;
    logic [WIDTH-1:0] q_shr, q_shl;

    assign q_shr = {s_in_msb, q[WIDTH-1:1]};
    assign q_shl = {q[WIDTH-2:0], s_in_lsb};

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        q_nxt     = q;
        case (state)
            SHIFT: begin
                q_nxt   = BURST_DIR ? q_shl : q_shr;
                cnt_nxt = cnt - 1'b1;
                if (cnt == CW'(1))
                    state_nxt = DONE;
            end
            default: begin
                // IDLE and DONE behave identically: DONE only differs in the done flag
                state_nxt = IDLE;
                if (start) begin
                    state_nxt = SHIFT;
                    cnt_nxt   = CW'(WIDTH);
                end else begin
                    case (mode)
                        MODE_SHR:  q_nxt = q_shr;
                        MODE_SHL:  q_nxt = q_shl;
                        MODE_LOAD: q_nxt = p_in;
                        default:   q_nxt = q;
                    endcase
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            q     <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            q     <= q_nxt;
        end
    end

    assign p_out     = q;
    assign s_out_lsb = q[0];
    assign s_out_msb = q[WIDTH-1];
    assign busy      = (state == SHIFT);
    assign done      = (state == DONE);

endmodule

// File: tb/tb_shift_reg_univ.sv
// tb/tb_shift_reg_univ.sv - directed self-checking bench for shift_reg_univ
module tb_shift_reg_univ;
    import shift_reg_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] mode;
    logic       s_in_msb, s_in_lsb, start;
    logic [7:0] p_in;
    logic [7:0] p_out_r, p_out_l;
    logic       s_out_lsb_r, s_out_msb_r, busy_r, done_r;
    logic       s_out_lsb_l, s_out_msb_l, busy_l, done_l;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    shift_reg_univ #(.WIDTH(8), .BURST_DIR(1'b0)) dut_r (
        .clk(clk), .rst(rst), .mode(mode), .s_in_msb(s_in_msb), .s_in_lsb(s_in_lsb),
        .p_in(p_in), .start(start), .p_out(p_out_r), .s_out_lsb(s_out_lsb_r),
        .s_out_msb(s_out_msb_r), .busy(busy_r), .done(done_r)
    );

    shift_reg_univ #(.WIDTH(8), .BURST_DIR(1'b1)) dut_l (
        .clk(clk), .rst(rst), .mode(mode), .s_in_msb(s_in_msb), .s_in_lsb(s_in_lsb),
        .p_in(p_in), .start(start), .p_out(p_out_l), .s_out_lsb(s_out_lsb_l),
        .s_out_msb(s_out_msb_l), .busy(busy_l), .done(done_l)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Runs the 8 busy cycles of a burst already accepted; data is the word held at acceptance.
    task automatic burst(input logic [7:0] data, input bit disturb);
        for (int k = 0; k < 8; k++) begin
            check($sformatf("busy_r[%0d]", k), busy_r, 1);
            check($sformatf("busy_l[%0d]", k), busy_l, 1);
            check($sformatf("done_r[%0d]", k), done_r, 0);
            check($sformatf("ser_r[%0d]", k), s_out_lsb_r, data[k]);
            check($sformatf("ser_l[%0d]", k), s_out_msb_l, data[7-k]);
            if (disturb) begin
                mode  = (k < 6) ? MODE_LOAD : MODE_HOLD;
                p_in  = 8'hFF;
                start = (k == 2);
            end
            tick();
        end
        mode  = MODE_HOLD;
        start = 1'b0;
        check("busy_r_end", busy_r, 0);
        check("busy_l_end", busy_l, 0);
        check("done_r_end", done_r, 1);
        check("done_l_end", done_l, 1);
    endtask

    initial begin
        rst = 1'b1; mode = MODE_HOLD; s_in_msb = 1'b0; s_in_lsb = 1'b0;
        p_in = 8'h00; start = 1'b0;
        tick(); tick();
        check("rst_p_out", p_out_r, 8'h00);
        check("rst_lsb", s_out_lsb_r, 0);
        check("rst_msb", s_out_msb_r, 0);
        check("rst_busy", busy_r, 0);
        check("rst_done", done_r, 0);
        rst = 1'b0;

        mode = MODE_LOAD; p_in = 8'hA5; tick();
        check("load_a5", p_out_r, 8'hA5);
        mode = MODE_HOLD; rst = 1'b1; tick(); rst = 1'b0;
        check("rst2_p_out", p_out_r, 8'h00);
        check("rst2_busy", busy_r, 0);
        check("rst2_done", done_r, 0);

        mode = MODE_LOAD; p_in = 8'h81; tick();
        mode = MODE_SHR; s_in_msb = 1'b1; tick();
        check("shr", p_out_r, 8'hC0);
        check("shr_msb_tap", s_out_msb_r, 1);
        mode = MODE_SHL; s_in_lsb = 1'b1; s_in_msb = 1'b0; tick();
        check("shl", p_out_r, 8'h81);
        check("shl_lsb_tap", s_out_lsb_r, 1);
        mode = MODE_HOLD; tick(); tick(); tick();
        check("hold3", p_out_r, 8'h81);

        // plain burst: right instance fills with 0, left with 1
        mode = MODE_LOAD; p_in = 8'hB4; tick();
        check("load_b4", p_out_l, 8'hB4);
        mode = MODE_SHR; start = 1'b1; s_in_msb = 1'b0; s_in_lsb = 1'b1; tick();
        start = 1'b0; mode = MODE_HOLD;
        check("start_no_shift", p_out_r, 8'hB4);
        burst(8'hB4, 1'b0);
        tick();
        check("done_drop_r", done_r, 0);
        check("done_drop_l", done_l, 0);
        check("final_r", p_out_r, 8'h00);
        check("final_l", p_out_l, 8'hFF);

        // burst with LOAD/start noise applied while busy
        mode = MODE_LOAD; p_in = 8'h3C; tick();
        mode = MODE_HOLD; start = 1'b1; tick(); start = 1'b0;
        burst(8'h3C, 1'b1);
        check("dist_final_r", p_out_r, 8'h00);
        check("dist_final_l", p_out_l, 8'hFF);

        // back-to-back start in DONE, then reset at busy cycle 3
        start = 1'b1; tick(); start = 1'b0;
        check("b2b_busy", busy_r, 1);
        tick(); tick(); tick();
        check("mid_busy3", busy_l, 1);
        rst = 1'b1; tick(); rst = 1'b0;
        check("midrst_busy_r", busy_r, 0);
        check("midrst_busy_l", busy_l, 0);
        check("midrst_done_l", done_l, 0);
        check("midrst_p_r", p_out_r, 8'h00);
        check("midrst_p_l", p_out_l, 8'h00);

        mode = MODE_LOAD; p_in = 8'h5A; tick(); mode = MODE_HOLD;
        start = 1'b1; tick(); start = 1'b0;
        burst(8'h5A, 1'b0);
        tick();
        check("post_final_r", p_out_r, 8'h00);
        check("post_final_l", p_out_l, 8'hFF);
        check("post_done", done_r, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
